// File: rtl/regfile_pkg.sv
// Shared defaults, read-source encoding and address helpers for the multiport register file.
package regfile_pkg;

  localparam int unsigned DefWidth = 16;
  localparam int unsigned DefDepth = 16;

  // Where a read port takes its data from this cycle.
  typedef enum logic [1:0] {
    SrcZero,
    SrcReg,
    SrcBypass
  } rd_src_e;

  // Index width, kept at least 1 so a two-entry file still has an address bit.
  function automatic int unsigned clog2(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : unsigned'($clog2(n));
  endfunction

  // Writes and reservations only land on in-range, non-hardwired registers.
  function automatic logic addr_writable(input int unsigned addr, input int unsigned depth,
                                         input bit zero_reg);
    return (addr < depth) && !(zero_reg && addr == 32'd0);
  endfunction

endpackage

// File: rtl/regfile_multiport_if.sv
// Write, reservation and read-port bundle of the multiport register file.
interface regfile_multiport_if import regfile_pkg::*; #(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = DefDepth
);
  localparam int unsigned AW = clog2(DEPTH);

  logic                   wrEn;
  logic [AW-1:0]          wrAddr;
  logic [WIDTH-1:0]       wrData;
  logic [AW-1:0]          rdAddrA;
  logic [AW-1:0]          rdAddrB;
  logic [WIDTH-1:0]       rdDataA;
  logic [WIDTH-1:0]       rdDataB;
  logic                   busyA;
  logic                   busyB;
  logic                   rsvEn;
  logic [AW-1:0]          rsvAddr;
  logic                   rsvStall;
  logic [WIDTH*DEPTH-1:0] regFlat;

  modport master (
    output wrEn, wrAddr, wrData, rdAddrA, rdAddrB, rsvEn, rsvAddr,
    input  rdDataA, rdDataB, busyA, busyB, rsvStall, regFlat
  );

  modport slave (
    input  wrEn, wrAddr, wrData, rdAddrA, rdAddrB, rsvEn, rsvAddr,
    output rdDataA, rdDataB, busyA, busyB, rsvStall, regFlat
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending-producer bits with busy lookups for both read ports and reservation stall.
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int unsigned DEPTH    = DefDepth,
  parameter int unsigned AW       = clog2(DEPTH),
  parameter bit          ZERO_REG = 1'b0,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic          rsv_en_i,
  input  logic [AW-1:0] rsv_addr_i,
  input  logic [AW-1:0] rd_addr_a_i,
  input  logic [AW-1:0] rd_addr_b_i,
  output logic          busy_a_o,
  output logic          busy_b_o,
  output logic          rsv_stall_o
);

  logic [DEPTH-1:0] pending_q, pending_d;
  logic             wr_ok;
  logic             rsv_ok;

  function automatic logic pend_at(input logic [DEPTH-1:0] pend, input logic [AW-1:0] a);
    return (32'(a) < DEPTH) ? pend[a] : 1'b0;
  endfunction

  assign wr_ok  = wr_en_i && addr_writable(32'(wr_addr_i), DEPTH, ZERO_REG);
  assign rsv_ok = rsv_en_i && addr_writable(32'(rsv_addr_i), DEPTH, ZERO_REG);

  // A retiring write to the same register frees it in time for the new reservation.
  assign rsv_stall_o = reset && rsv_ok && pend_at(pending_q, rsv_addr_i) &&
                       !(wr_en_i && wr_addr_i == rsv_addr_i);

  assign busy_a_o = reset && pend_at(pending_q, rd_addr_a_i) &&
                    !(BYPASS && wr_en_i && wr_addr_i == rd_addr_a_i);
  assign busy_b_o = reset && pend_at(pending_q, rd_addr_b_i) &&
                    !(BYPASS && wr_en_i && wr_addr_i == rd_addr_b_i);

  // Set after clear, so a same-cycle write and reservation leaves the new producer pending.
  always_comb begin
    pending_d = pending_q;
    if (wr_ok) begin
      pending_d[wr_addr_i] = 1'b0;
    end
    if (rsv_ok && !rsv_stall_o) begin
      pending_d[rsv_addr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

endmodule

// File: rtl/regfile_multiport.sv
// Two-read, one-write register file with write bypass, optional zero register and a
// reservation scoreboard for multi-cycle producers.
module regfile_multiport import regfile_pkg::*; #(
  parameter int unsigned WIDTH    = DefWidth,
  parameter int unsigned DEPTH    = DefDepth,
  parameter bit          ZERO_REG = 1'b0,
  parameter bit          BYPASS   = 1'b1
) (
  input logic               clk,
  input logic               reset,
  regfile_multiport_if.slave bus
);

  localparam int unsigned AW = clog2(DEPTH);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic             wr_ok;
  rd_src_e          src_a, src_b;
  logic [WIDTH-1:0] rd_a, rd_b;

  assign wr_ok = bus.wrEn && addr_writable(32'(bus.wrAddr), DEPTH, ZERO_REG);

  function automatic rd_src_e rd_src(input logic rst_n, input logic wr_ok_f,
                                     input logic [AW-1:0] wa, input logic [AW-1:0] ra);
    if (!rst_n || 32'(ra) >= DEPTH) begin
      return SrcZero;
    end
    if (BYPASS && wr_ok_f && wa == ra) begin
      return SrcBypass;
    end
    return SrcReg;
  endfunction

  always_comb begin
    src_a = rd_src(reset, wr_ok, bus.wrAddr, bus.rdAddrA);
    src_b = rd_src(reset, wr_ok, bus.wrAddr, bus.rdAddrB);
  end

  always_comb begin
    rd_a = '0;
    rd_b = '0;
    unique case (src_a)
      SrcReg:    rd_a = regs_q[bus.rdAddrA];
      SrcBypass: rd_a = bus.wrData;
      default:   rd_a = '0;
    endcase
    unique case (src_b)
      SrcReg:    rd_b = regs_q[bus.rdAddrB];
      SrcBypass: rd_b = bus.wrData;
      default:   rd_b = '0;
    endcase
  end

  assign bus.rdDataA = rd_a;
  assign bus.rdDataB = rd_b;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_ok) begin
      regs_q[bus.wrAddr] <= bus.wrData;
    end
  end

  // Debug view shows stored contents only, never the bypass path.
  for (genvar i = 0; i < int'(DEPTH); i++) begin : g_flat
    assign bus.regFlat[i*WIDTH +: WIDTH] = regs_q[i];
  end

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .wr_en_i     (bus.wrEn),
    .wr_addr_i   (bus.wrAddr),
    .rsv_en_i    (bus.rsvEn),
    .rsv_addr_i  (bus.rsvAddr),
    .rd_addr_a_i (bus.rdAddrA),
    .rd_addr_b_i (bus.rdAddrB),
    .busy_a_o    (bus.busyA),
    .busy_b_o    (bus.busyB),
    .rsv_stall_o (bus.rsvStall)
  );

endmodule

// File: doc/regfile_multiport.md
REGFILE_MULTIPORT -- requirements
Module: regfile_multiport

Interface
REQ-001 Parameter WIDTH, default 16, data bits per register.
REQ-002 Parameter DEPTH, default 16, number of registers (2..256).
REQ-003 Parameter ZERO_REG, default 0; when 1, register 0 always reads 0, ignores writes and is never busy.
REQ-004 Parameter BYPASS, default 1; when 1, same-cycle write data is forwarded to the read ports.
REQ-005 Local AW = clog2(DEPTH), derived from DEPTH, not overridable.
REQ-006 clk  in  1  single clock; all state updates on the rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 wrEn  in  1  write strobe.
REQ-009 wrAddr  in  AW  write register index.
REQ-010 wrData  in  WIDTH  write data (ALU result bus).
REQ-011 rdAddrA / rdAddrB  in  AW  read-port indices.
REQ-012 rdDataA / rdDataB  out  WIDTH  read-port data.
REQ-013 busyA / busyB  out  1  addressed register has a pending producer.
REQ-014 rsvEn  in  1  reserve request (multi-cycle op issued).
REQ-015 rsvAddr  in  AW  register to reserve.
REQ-016 rsvStall  out  1  reservation refused this cycle.
REQ-017 regFlat  out  WIDTH*DEPTH  all registers concatenated, register i at bits [i*WIDTH +: WIDTH], for debug/display.

Function
REQ-018 Reads SHALL be combinational: rdDataX = reg[rdAddrX], 0-cycle latency.
REQ-019 On a rising edge with wrEn=1 and wrAddr valid, reg[wrAddr] SHALL take wrData; all other registers SHALL hold.
REQ-020 With BYPASS=1, wrEn=1 and wrAddr==rdAddrX, rdDataX SHALL equal wrData in that same cycle; with BYPASS=0 it SHALL show the old value.
REQ-021 With ZERO_REG=1, address 0: reads return 0, writes and reservations are ignored, busy=0, rsvStall=0.
REQ-022 Addresses >= DEPTH: writes and reservations ignored, reads return 0, busy=0, rsvStall=0.
REQ-023 Scoreboard: one pending bit per register; rsvEn=1 (not stalled) sets pending[rsvAddr] at the edge.
REQ-024 wrEn=1 SHALL clear pending[wrAddr] at the edge.
REQ-025 Simultaneous wrEn and rsvEn to the same address: data written AND pending ends at 1 (new producer wins).
REQ-026 busyX = pending[rdAddrX], except 0 when BYPASS=1 and wrEn=1 and wrAddr==rdAddrX.
REQ-027 rsvStall = rsvEn and pending[rsvAddr] and not (wrEn and wrAddr==rsvAddr); a stalled reservation SHALL NOT alter state.
REQ-028 Both read ports SHALL be fully independent; identical addresses return identical data/busy.
REQ-029 regFlat SHALL reflect registered contents only (no bypass).

Reset
REQ-030 reset=0 SHALL immediately (asynchronously) clear all registers to 0 and all pending bits to 0.
REQ-031 During reset, rdData=0, busy=0, rsvStall=0 regardless of inputs (rsvStall forced low).
REQ-032 Reset asserted mid-reservation SHALL discard the reservation; first edge after release behaves as from power-up.

Structure
REQ-033 Default WIDTH/DEPTH and the clog2 helper SHALL live in the shared regfile_pkg.
REQ-034 Pending-bit logic SHALL be a sub-module regfile_scoreboard (DEPTH, AW parameters); storage and read muxing stay in the top.

Verification
REQ-035 Reset; write 16'hA5A5 to r3; read A=3 next cycle -> rdDataA=A5A5, regFlat[63:48]=A5A5.
REQ-036 BYPASS=1: wrEn r5=16'h1234, rdAddrA=5 same cycle -> rdDataA=1234; BYPASS=0 -> 0000.
REQ-037 rsv r7; next cycle rdAddrB=7 -> busyB=1; rsv r7 again -> rsvStall=1; write r7 -> busyB=0 (same cycle with BYPASS=1).
REQ-038 Same-cycle wrEn and rsvEn on r2 with wrData 16'h00FF -> r2=00FF, busy=1 afterwards.
REQ-039 ZERO_REG=1: write 16'hFFFF to r0, rsv r0 -> rdData=0, busy=0, rsvStall=0.
REQ-040 Reserve r9, write r4, assert reset between edges -> all outputs 0 immediately; after release busy(r9)=0, r4=0.
